// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-side arbiter.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   localparam int unsigned CNT_W = 16;

   // Index width for a pointer over n entries; never narrower than one bit.
   function automatic int unsigned ptr_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set bit of req at or after start, wrapping.
module rr_picker #(
   parameter int unsigned N = 4,
   parameter int unsigned W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] start,
   output logic         found,
   output logic [W-1:0] idx
);

   int unsigned pos;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      pos   = 0;
      for (int unsigned k = 0; k < N; k++) begin
         pos = (32'(start) + k) % N;
         if (!found && req[pos[W-1:0]]) begin
            found = 1'b1;
            idx   = pos[W-1:0];
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of a single FIFO, grants capped at BURST writes.
// Define FIFO_ARB_STATS_EN to add per-requester write counters and a stall counter.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter  int unsigned NREQ  = 4,
   parameter  int unsigned WIDTH = 16,
   parameter  int unsigned BURST = 4,
   localparam int unsigned OW    = ptr_w(NREQ),
   localparam int unsigned BW    = ptr_w(BURST + 1)
) (
   input  logic                  clk,
   input  logic                  rst_,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] req_data,
   input  logic                  fifo_full,
   output logic [NREQ-1:0]       gnt,
   output logic [OW-1:0]         owner,
   output logic                  busy,
   output logic                  fifo_write,
`ifdef FIFO_ARB_STATS_EN
   output logic [NREQ*CNT_W-1:0] wr_cnt,
   output logic [CNT_W-1:0]      stall_cnt,
`endif
   output logic [WIDTH-1:0]      fifo_data_in
);

   arb_state_t       state, state_nxt;
   logic [OW-1:0]    owner_nxt;
   logic [OW-1:0]    last, last_nxt;
   logic [BW-1:0]    bcnt, bcnt_nxt;
   logic [OW-1:0]    pick_start;
   logic             pick_found;
   logic [OW-1:0]    pick_idx;
   logic             owner_req;
   logic             grant_end;
   logic [WIDTH-1:0] sel_data;

   function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] i);
      return (i == OW'(NREQ - 1)) ? '0 : i + 1'b1;
   endfunction

   // One picker serves both paths: IDLE searches past last, GRANT hands off past owner.
   assign pick_start = wrap_inc((state == IDLE) ? last : owner);

   rr_picker #(
      .N (NREQ),
      .W (OW)
   ) u_pick (
      .req   (req),
      .start (pick_start),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state <= IDLE;
         owner <= '0;
         last  <= OW'(NREQ - 1);
         bcnt  <= '0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
         last  <= last_nxt;
         bcnt  <= bcnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      last_nxt  = last;
      bcnt_nxt  = bcnt;
      grant_end = 1'b0;
      case (state)
         IDLE: begin
            if (pick_found) begin
               state_nxt = GRANT;
               owner_nxt = pick_idx;
               last_nxt  = pick_idx;
               bcnt_nxt  = '0;
            end
         end
         GRANT: begin
            grant_end = !owner_req || (fifo_write && (bcnt == BW'(BURST - 1)));
            if (grant_end) begin
               bcnt_nxt = '0;
               if (pick_found) begin
                  owner_nxt = pick_idx;
                  last_nxt  = pick_idx;
               end else begin
                  state_nxt = IDLE;
               end
            end else if (fifo_write) begin
               bcnt_nxt = bcnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state == GRANT);
      owner_req  = req[owner];
      fifo_write = busy && owner_req && !fifo_full;
      sel_data   = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (owner == OW'(i))
            sel_data = req_data[i*WIDTH +: WIDTH];
      end
      fifo_data_in = fifo_write ? sel_data : '0;
      gnt = '0;
      if (busy)
         gnt[owner] = 1'b1;
   end

`ifdef FIFO_ARB_STATS_EN
   logic [CNT_W-1:0] wr_cnt_q [NREQ];

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         for (int unsigned i = 0; i < NREQ; i++)
            wr_cnt_q[i] <= '0;
         stall_cnt <= '0;
      end else begin
         for (int unsigned i = 0; i < NREQ; i++) begin
            if (fifo_write && (owner == OW'(i)) && (wr_cnt_q[i] != '1))
               wr_cnt_q[i] <= wr_cnt_q[i] + 1'b1;
         end
         if (busy && owner_req && fifo_full && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

   always_comb begin
      wr_cnt = '0;
      for (int unsigned i = 0; i < NREQ; i++)
         wr_cnt[i*CNT_W +: CNT_W] = wr_cnt_q[i];
   end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NREQ=4, WIDTH=16, BURST=4).
module tb_fifo_wr_arbiter;

   localparam int unsigned NREQ  = 4;
   localparam int unsigned WIDTH = 16;
   localparam int unsigned BURST = 4;

   logic                  clk = 1'b0;
   logic                  rst_;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] req_data;
   logic                  fifo_full;
   logic [NREQ-1:0]       gnt;
   logic [1:0]            owner;
   logic                  busy;
   logic                  fifo_write;
   logic [WIDTH-1:0]      fifo_data_in;
`ifdef FIFO_ARB_STATS_EN
   logic [NREQ*16-1:0]    wr_cnt;
   logic [15:0]           stall_cnt;
`endif

   logic [WIDTH-1:0] dat [NREQ];
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   always_comb req_data = {dat[3], dat[2], dat[1], dat[0]};

   fifo_wr_arbiter #(
      .NREQ  (NREQ),
      .WIDTH (WIDTH),
      .BURST (BURST)
   ) dut (
      .clk          (clk),
      .rst_         (rst_),
      .req          (req),
      .req_data     (req_data),
      .fifo_full    (fifo_full),
      .gnt          (gnt),
      .owner        (owner),
      .busy         (busy),
      .fifo_write   (fifo_write),
`ifdef FIFO_ARB_STATS_EN
      .wr_cnt       (wr_cnt),
      .stall_cnt    (stall_cnt),
`endif
      .fifo_data_in (fifo_data_in)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_default_data();
      dat[0] = 16'h1111;
      dat[1] = 16'h2222;
      dat[2] = 16'h3333;
      dat[3] = 16'h4444;
   endtask

   task automatic do_reset();
      rst_      = 1'b0;
      req       = '0;
      fifo_full = 1'b0;
      set_default_data();
      tick();
      rst_ = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst_      = 1'b0;
      req       = 4'b1111;
      fifo_full = 1'b0;
      set_default_data();
      tick();
      tick();
      #1;
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt: got %b expected 0000", gnt); end
      checks++; if (fifo_write !== 1'b0) begin errors++; $display("FAIL rst_write: got %b expected 0", fifo_write); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
      checks++; if (owner !== 2'd0) begin errors++; $display("FAIL rst_owner: got %0d expected 0", owner); end
      checks++; if (fifo_data_in !== 16'h0000) begin errors++; $display("FAIL rst_data: got %h expected 0000", fifo_data_in); end
      rst_ = 1'b1;
      #1;
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_release_gnt: got %b expected 0000", gnt); end
      tick();
      #1;
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rst_first_gnt: got %b expected 0001", gnt); end
      checks++; if (fifo_write !== 1'b1) begin errors++; $display("FAIL rst_first_write: got %b expected 1", fifo_write); end
      checks++; if (fifo_data_in !== 16'h1111) begin errors++; $display("FAIL rst_first_data: got %h expected 1111", fifo_data_in); end
   endtask

   task automatic test_round_robin();
      int unsigned e;
      logic [3:0]  eg;
      do_reset();
      req = 4'b0011;
      #1;
      checks++; if (fifo_write !== 1'b0) begin errors++; $display("FAIL rr_idle_write: got %b expected 0", fifo_write); end
      for (int k = 0; k < 16; k++) begin
         tick();
         #1;
         e  = ((k / 4) % 2 == 0) ? 0 : 1;
         eg = 4'b0001 << e;
         checks++; if (gnt !== eg) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", k, gnt, eg); end
         checks++; if (fifo_write !== 1'b1) begin errors++; $display("FAIL rr_write[%0d]: got %b expected 1", k, fifo_write); end
         checks++; if (fifo_data_in !== dat[e]) begin errors++; $display("FAIL rr_data[%0d]: got %h expected %h", k, fifo_data_in, dat[e]); end
      end
      tick();
      req = '0;
      #1;
`ifdef FIFO_ARB_STATS_EN
      checks++; if (wr_cnt[15:0] !== 16'd8) begin errors++; $display("FAIL rr_wr_cnt0: got %0d expected 8", wr_cnt[15:0]); end
      checks++; if (wr_cnt[31:16] !== 16'd8) begin errors++; $display("FAIL rr_wr_cnt1: got %0d expected 8", wr_cnt[31:16]); end
`endif
      tick();
   endtask

   task automatic test_single_owner();
      logic [15:0] ed;
      do_reset();
      req    = 4'b0100;
      dat[2] = 16'h0020;
      #1;
      checks++; if (fifo_write !== 1'b0) begin errors++; $display("FAIL single_idle_write: got %b expected 0", fifo_write); end
      for (int k = 0; k < 6; k++) begin
         tick();
         ed     = 16'h0020 + 16'(k);
         dat[2] = ed;
         #1;
         checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt[%0d]: got %b expected 0100", k, gnt); end
         checks++; if (fifo_write !== 1'b1) begin errors++; $display("FAIL single_write[%0d]: got %b expected 1", k, fifo_write); end
         checks++; if (fifo_data_in !== ed) begin errors++; $display("FAIL single_data[%0d]: got %h expected %h", k, fifo_data_in, ed); end
      end
      tick();
      req = '0;
      set_default_data();
      tick();
   endtask

   task automatic test_full_stall();
      do_reset();
      req = 4'b1001;
      for (int k = 0; k < 2; k++) begin
         tick();
         #1;
         checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL stall_pre_gnt[%0d]: got %b expected 0001", k, gnt); end
         checks++; if (fifo_write !== 1'b1) begin errors++; $display("FAIL stall_pre_write[%0d]: got %b expected 1", k, fifo_write); end
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         fifo_full = 1'b1;
         #1;
         checks++; if (fifo_write !== 1'b0) begin errors++; $display("FAIL stall_write[%0d]: got %b expected 0", k, fifo_write); end
         checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL stall_gnt[%0d]: got %b expected 0001", k, gnt); end
         checks++; if (fifo_data_in !== 16'h0000) begin errors++; $display("FAIL stall_data[%0d]: got %h expected 0000", k, fifo_data_in); end
      end
      for (int k = 0; k < 2; k++) begin
         tick();
         fifo_full = 1'b0;
         #1;
         checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL stall_post_gnt[%0d]: got %b expected 0001", k, gnt); end
         checks++; if (fifo_write !== 1'b1) begin errors++; $display("FAIL stall_post_write[%0d]: got %b expected 1", k, fifo_write); end
      end
      tick();
      #1;
      checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL stall_handoff_gnt: got %b expected 1000", gnt); end
      checks++; if (fifo_write !== 1'b1) begin errors++; $display("FAIL stall_handoff_write: got %b expected 1", fifo_write); end
      checks++; if (fifo_data_in !== 16'h4444) begin errors++; $display("FAIL stall_handoff_data: got %h expected 4444", fifo_data_in); end
`ifdef FIFO_ARB_STATS_EN
      checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL stall_cnt: got %0d expected 3", stall_cnt); end
`endif
      tick();
      req = '0;
      tick();
   endtask

   task automatic test_release();
      do_reset();
      req = 4'b1010;
      for (int k = 0; k < 2; k++) begin
         tick();
         #1;
         checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rel_gnt[%0d]: got %b expected 0010", k, gnt); end
         checks++; if (fifo_data_in !== 16'h2222) begin errors++; $display("FAIL rel_data[%0d]: got %h expected 2222", k, fifo_data_in); end
      end
      tick();
      req = 4'b1000;
      #1;
      checks++; if (fifo_write !== 1'b0) begin errors++; $display("FAIL rel_gap_write: got %b expected 0", fifo_write); end
      checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rel_gap_gnt: got %b expected 0010", gnt); end
      tick();
      #1;
      checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL rel_next_gnt: got %b expected 1000", gnt); end
      checks++; if (fifo_write !== 1'b1) begin errors++; $display("FAIL rel_next_write: got %b expected 1", fifo_write); end
      checks++; if (fifo_data_in !== 16'h4444) begin errors++; $display("FAIL rel_next_data: got %h expected 4444", fifo_data_in); end
      tick();
      req = '0;
      tick();
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      req = 4'b0001;
      tick();
      #1;
      checks++; if (fifo_write !== 1'b1) begin errors++; $display("FAIL mid_pre_write: got %b expected 1", fifo_write); end
      rst_ = 1'b0;
      #1;
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL mid_async_gnt: got %b expected 0000", gnt); end
      checks++; if (fifo_write !== 1'b0) begin errors++; $display("FAIL mid_async_write: got %b expected 0", fifo_write); end
      tick();
      rst_ = 1'b1;
      req  = 4'b0011;
      tick();
      #1;
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_restart_gnt: got %b expected 0001", gnt); end
      checks++; if (fifo_data_in !== 16'h1111) begin errors++; $display("FAIL mid_restart_data: got %h expected 1111", fifo_data_in); end
      req = '0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_round_robin();
      test_single_owner();
      test_full_stall();
      test_release();
      test_reset_mid_burst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
